bcd7seg_seq_display: RTL
========================

// Module: bcd7seg_seq_display
// PURPOSE
//   Sequential, parametrised binary-to-7-segment display driver. Accepts a sign-magnitude
//   value via valid/ready and converts it to BCD with a shift-add-3 (double-dabble)
//   engine, one bit per cycle. It then drives DIGITS registered seven-segment digits plus
//   a sign digit. Sits between the remote-control value datapath and the board displays.
// PARAMETERS
//   IN_W       8  magnitude width in bits (>=2); in_data is IN_W+1 bits, MSB = sign
//   DIGITS     3  number of decimal digits driven (>=1)
//   BLANK_LZ   1  1 = blank leading zeros (digit 0 is never blanked); 0 = show all zeros
//   ACT_LOW    1  1 = segment on when 0; 0 = invert all segment outputs
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          async reset, active high
//   in_valid   in   1          in_data valid
//   in_ready   out  1          converter idle, can accept
//   in_data    in   IN_W+1     [IN_W] = sign (1 = negative), [IN_W-1:0] = magnitude
//   seg        out  7*DIGITS   digit k at seg[7k+6:7k], order {a,b,c,d,e,f,g}, k=0 = units
//   seg_sign   out  7          sign digit {a..g}
//   out_valid  out  1          1-cycle pulse: seg/seg_sign/overflow just updated
//   overflow   out  1          last magnitude > 10^DIGITS-1
// BEHAVIOUR
//   Reset (async, no clock needed): in_ready=1, out_valid=0, overflow=0, all seg and
//     seg_sign = BLANK. Internal state -> IDLE. All conversion state is discarded.
//   Codes (ACT_LOW=1): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//     6=0100000 7=0001111 8=0000000 9=0000100 BLANK=1111111 DASH=1111110.
//     ACT_LOW=0: every code is bitwise inverted.
//   Internal BCD register: NB = ceil(IN_W*log10(2)) digits, at least DIGITS.
//     Values: IN_W=8 -> NB=3; IN_W=16 -> NB=5.
//   FSM IDLE -> SHIFT -> ENCODE -> IDLE:
//     IDLE: in_ready=1. On in_valid&&in_ready, latch sign and magnitude, clear BCD,
//       bit counter = IN_W. Go to SHIFT.
//     SHIFT: in_ready=0. Each cycle, add 3 to every BCD nibble >=5, then shift
//       {bcd,mag} left by 1 and decrement the counter. After IN_W cycles go to ENCODE.
//     ENCODE: register seg, seg_sign and overflow; out_valid=1 for this cycle only.
//       Return to IDLE.
//   Latency: accept edge to out_valid = IN_W+1 cycles, so a new accept is possible
//     every IN_W+2 cycles. in_data is ignored while busy; the upstream holds it.
//   Outputs hold their values between updates.
//   Overflow: any BCD digit at index >= DIGITS is nonzero -> overflow=1, all DIGITS = DASH.
//   Leading-zero blanking (BLANK_LZ=1): digit k>0 = BLANK if it and all higher digits are 0.
//   Sign: seg_sign = DASH if sign=1 && magnitude!=0, else BLANK. Negative zero shows as 0.
//     Under overflow, seg_sign still follows the sign rule.
//   Nibble values 10..15 never occur after a correct conversion. Encoder default = BLANK.
//   rst asserted mid-conversion aborts the conversion; no out_valid pulse is produced.
// TESTING
//   1 Reset: rst=1 -> in_ready=1, out_valid=0, seg=all 1111111, seg_sign=1111111.
//   2 Defaults, in_data=9'h0FF (+255) -> out_valid after 9 cycles;
//     seg={0010010,0100100,0100100}, seg_sign=BLANK, overflow=0.
//   3 Defaults, in_data=9'h107 (-7) -> digit0=0001111, digits 1,2 BLANK, seg_sign=1111110.
//     Repeat with BLANK_LZ=0 -> digits 1,2=0000001.
//   4 DIGITS=2, in_data=+100 -> overflow=1, both digits 1111110. Then +99 -> overflow=0,
//     both digits 0000100.
//   5 Negative zero 9'h100 -> digit0=0000001, seg_sign=BLANK.
//     Back-to-back accepts with in_valid held high -> accepts exactly 10 cycles apart.
//   6 rst pulse at SHIFT cycle 4 -> no out_valid. Outputs = reset values. The next
//     conversion completes correctly. IN_W=16, DIGITS=5, 65535 -> 6,5,5,3,5 correct.

Source files
------------

// File: rtl/bcd7seg_seq_display_if.sv
// Value-in / segments-out bundle for the sequential 7-segment display driver.
// The master side is the upstream value source; the slave side is the driver itself.
interface bcd7seg_seq_display_if #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W:0]         in_data;    // [IN_W] = sign, [IN_W-1:0] = magnitude
  logic [7*DIGITS-1:0]   seg;        // digit k at [7k+6:7k], {a..g}, k=0 = units
  logic [6:0]            seg_sign;
  logic                  out_valid;
  logic                  overflow;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  seg,
    input  seg_sign,
    input  out_valid,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output seg,
    output seg_sign,
    output out_valid,
    output overflow
  );
endinterface

// File: rtl/bcd7seg_seq_display.sv
// Sequential sign-magnitude to 7-segment display driver. A double-dabble engine converts
// one magnitude bit per cycle, then the BCD result is encoded into DIGITS segment digits
// plus a sign digit, with optional leading-zero blanking and overflow dashes.
module bcd7seg_seq_display #(
  parameter int unsigned IN_W     = 8,
  parameter int unsigned DIGITS   = 3,
  parameter bit          BLANK_LZ = 1'b1,
  parameter bit          ACT_LOW  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  bcd7seg_seq_display_if.slave bus
);

  // ceil(IN_W * log10(2)) in fixed point: decimal digits needed for 2^IN_W - 1
  localparam int unsigned NbMin = (IN_W * 30103 + 99999) / 100000;
  localparam int unsigned NB    = (NbMin > DIGITS) ? NbMin : DIGITS;
  localparam int unsigned CntW  = $clog2(IN_W + 1);

  // Codes below are written segment-on-low; the mask flips them for active-high boards
  localparam logic [6:0] InvMask  = ACT_LOW ? 7'b0000000 : 7'b1111111;
  localparam logic [6:0] SegBlank = 7'b1111111 ^ InvMask;
  localparam logic [6:0] SegDash  = 7'b1111110 ^ InvMask;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StEncode
  } state_e;

  // Nibbles 10..15 cannot come out of a correct conversion; show them blank
  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'b0000001;
      4'd1:    code = 7'b1001111;
      4'd2:    code = 7'b0010010;
      4'd3:    code = 7'b0000110;
      4'd4:    code = 7'b1001100;
      4'd5:    code = 7'b0100100;
      4'd6:    code = 7'b0100000;
      4'd7:    code = 7'b0001111;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0000100;
      default: code = 7'b1111111;
    endcase
    return code ^ InvMask;
  endfunction

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [IN_W-1:0]     mag_q;
  logic [4*NB-1:0]     bcd_q;
  logic [4*NB-1:0]     bcd_adj;
  logic                sign_q;
  logic                nz_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                overflow_q;
  logic                overflow_d;
  logic [7*DIGITS-1:0] seg_q;
  logic [7*DIGITS-1:0] seg_d;
  logic [6:0]          seg_sign_q;
  logic [6:0]          seg_sign_d;
  logic                higher_zero;
  logic [3:0]          nib_k;

  // Add-3 correction of every nibble >= 5 ahead of the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NB); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Segment image of the finished BCD value: overflow dashes, blanking, sign digit
  always_comb begin
    overflow_d  = 1'b0;
    seg_d       = '0;
    higher_zero = 1'b1;
    nib_k       = 4'd0;
    for (int i = int'(DIGITS); i < int'(NB); i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        overflow_d = 1'b1;
      end
    end
    // Walk from the most significant digit so higher_zero covers all digits above k
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      nib_k = bcd_q[4*k +: 4];
      if (overflow_d) begin
        seg_d[7*k +: 7] = SegDash;
      end else if (BLANK_LZ && (k > 0) && higher_zero && (nib_k == 4'd0)) begin
        seg_d[7*k +: 7] = SegBlank;
      end else begin
        seg_d[7*k +: 7] = encode(nib_k);
      end
      higher_zero = higher_zero && (nib_k == 4'd0);
    end
    // Negative zero is shown unsigned
    seg_sign_d = (sign_q && nz_q) ? SegDash : SegBlank;
  end

  // Control FSM with the conversion datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      nz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      seg_q       <= {DIGITS{SegBlank}};
      seg_sign_q  <= SegBlank;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            sign_q     <= bus.in_data[IN_W];
            nz_q       <= |bus.in_data[IN_W-1:0];
            mag_q      <= bus.in_data[IN_W-1:0];
            bcd_q      <= '0;
            cnt_q      <= CntW'(IN_W);
            in_ready_q <= 1'b0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          {bcd_q, mag_q} <= {bcd_adj[4*NB-2:0], mag_q, 1'b0};
          cnt_q          <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StEncode;
          end
        end
        StEncode: begin
          seg_q       <= seg_d;
          seg_sign_q  <= seg_sign_d;
          overflow_q  <= overflow_d;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.seg       = seg_q;
  assign bus.seg_sign  = seg_sign_q;

endmodule
